// File: rtl/uart_rx_word_packer.sv
// uart_rx_word_packer
// Receives 8N1 UART frames, packs four bytes little-endian into a 32-bit
// word and buffers completed words in a single-clock FIFO that the consumer
// drains with a req/ack + read-enable handshake.
module uart_rx_word_packer #(
    parameter int CLK_FRE           = 50,
    parameter int BAUD_RATE         = 115200,
    parameter int FIFO_DEPTH        = 16,
    parameter int IDLE_TIMEOUT_BITS = 20
) (
    input  logic                          sys_clk,
    input  logic                          rst_n,
    input  logic                          uart_rx,
    input  logic                          read_req,
    output logic                          read_req_ack,
    input  logic                          read_en,
    output logic [31:0]                   read_data,
    output logic                          read_data_valid,
    output logic [$clog2(FIFO_DEPTH):0]   word_count,
    output logic                          frame_err,
    output logic                          overflow,
    output logic                          partial_drop
);

    localparam int CYCLE_PER_BIT = CLK_FRE * 1000000 / BAUD_RATE;
    localparam int HALF_BIT      = CYCLE_PER_BIT / 2;
    localparam int CLK_CNT_W     = $clog2(CYCLE_PER_BIT);
    localparam int IDLE_LIMIT    = IDLE_TIMEOUT_BITS * CYCLE_PER_BIT;
    localparam int IDLE_CNT_W    = $clog2(IDLE_LIMIT + 1);
    localparam int ADDR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_W         = ADDR_W + 1;

    localparam logic [CLK_CNT_W-1:0]  HALF_END = CLK_CNT_W'(HALF_BIT - 1);
    localparam logic [CLK_CNT_W-1:0]  BIT_END  = CLK_CNT_W'(CYCLE_PER_BIT - 1);
    localparam logic [IDLE_CNT_W-1:0] IDLE_END = IDLE_CNT_W'(IDLE_LIMIT - 1);
    localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    // ------------------------------------------------------------------
    // Input synchroniser and falling-edge detect
    // ------------------------------------------------------------------
    logic rx_meta_r;
    logic rx_sync_r;
    logic rx_prev_r;
    logic fall_s;

    // Two-flop synchroniser plus one history flop; all reset to line idle (1).
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= uart_rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    assign fall_s = rx_prev_r & ~rx_sync_r;

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    rx_state_t             state_r;
    rx_state_t             state_nxt_s;
    logic [CLK_CNT_W-1:0]  clk_cnt_r;
    logic [CLK_CNT_W-1:0]  clk_cnt_nxt_s;
    logic [2:0]            bit_idx_r;
    logic [2:0]            bit_idx_nxt_s;
    logic [7:0]            shift_r;
    logic [7:0]            shift_nxt_s;
    logic                  byte_ok_s;
    logic                  byte_bad_s;

    // Receive FSM state and bit-timing registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            clk_cnt_r <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            state_r   <= state_nxt_s;
            clk_cnt_r <= clk_cnt_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            shift_r   <= shift_nxt_s;
        end
    end

    // Next-state logic: start-bit validation at half bit, data/stop sampling at bit centres.
    always_comb begin
        state_nxt_s   = state_r;
        clk_cnt_nxt_s = clk_cnt_r;
        bit_idx_nxt_s = bit_idx_r;
        shift_nxt_s   = shift_r;
        byte_ok_s     = 1'b0;
        byte_bad_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fall_s) begin
                    state_nxt_s   = ST_START;
                    clk_cnt_nxt_s = '0;
                    bit_idx_nxt_s = 3'd0;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_START: begin
                if (clk_cnt_r == HALF_END) begin
                    clk_cnt_nxt_s = '0;
                    if (rx_sync_r == 1'b0) begin
                        state_nxt_s = ST_DATA;
                    end else begin
                        // Line went back high before mid start bit: treat as noise.
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    clk_cnt_nxt_s = clk_cnt_r + CLK_CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (clk_cnt_r == BIT_END) begin
                    clk_cnt_nxt_s = '0;
                    shift_nxt_s   = {rx_sync_r, shift_r[7:1]};
                    bit_idx_nxt_s = bit_idx_r + 3'd1;
                    if (bit_idx_r == 3'd7) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    clk_cnt_nxt_s = clk_cnt_r + CLK_CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (clk_cnt_r == BIT_END) begin
                    // Leave STOP in the sampling cycle so a back-to-back start bit is caught.
                    clk_cnt_nxt_s = '0;
                    state_nxt_s   = ST_IDLE;
                    if (rx_sync_r == 1'b1) begin
                        byte_ok_s = 1'b1;
                    end else begin
                        byte_bad_s = 1'b1;
                    end
                end else begin
                    clk_cnt_nxt_s = clk_cnt_r + CLK_CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                clk_cnt_nxt_s = '0;
                bit_idx_nxt_s = 3'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Partial-word idle timeout
    // ------------------------------------------------------------------
    logic [1:0]            byte_cnt_r;
    logic [IDLE_CNT_W-1:0] idle_cnt_r;
    logic                  idle_run_s;
    logic                  timeout_s;

    assign idle_run_s = (state_r == ST_IDLE) && (byte_cnt_r != 2'd0) && !fall_s;
    assign timeout_s  = idle_run_s && (idle_cnt_r == IDLE_END);

    // Idle counter: only runs while a partial word waits for more bytes.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_r <= '0;
        end else if (idle_run_s && !timeout_s) begin
            idle_cnt_r <= idle_cnt_r + IDLE_CNT_W'(1);
        end else begin
            idle_cnt_r <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Byte packing and status pulses
    // ------------------------------------------------------------------
    logic [31:0] word_r;
    logic        push_r;
    logic        frame_err_r;
    logic        partial_drop_r;

    // Little-endian packing; framing errors and timeouts restart word alignment.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_r     <= 2'd0;
            word_r         <= 32'h0000_0000;
            push_r         <= 1'b0;
            frame_err_r    <= 1'b0;
            partial_drop_r <= 1'b0;
        end else begin
            push_r         <= 1'b0;
            frame_err_r    <= 1'b0;
            partial_drop_r <= 1'b0;
            if (byte_ok_s) begin
                word_r[{byte_cnt_r, 3'b000} +: 8] <= shift_r;
                if (byte_cnt_r == 2'd3) begin
                    push_r     <= 1'b1;
                    byte_cnt_r <= 2'd0;
                end else begin
                    byte_cnt_r <= byte_cnt_r + 2'd1;
                end
            end else if (byte_bad_s) begin
                frame_err_r <= 1'b1;
                byte_cnt_r  <= 2'd0;
            end else if (timeout_s) begin
                partial_drop_r <= 1'b1;
                byte_cnt_r     <= 2'd0;
            end else begin
                byte_cnt_r <= byte_cnt_r;
            end
        end
    end

    // ------------------------------------------------------------------
    // Word FIFO and read side
    // ------------------------------------------------------------------
    logic [31:0]       mem_r [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              pop_s;
    logic              push_ok_s;
    logic              overflow_r;
    logic              ack_r;
    logic [31:0]       read_data_r;
    logic              read_valid_r;

    // A full FIFO still takes a push when a pop frees the slot in the same cycle.
    assign pop_s     = read_en && (count_r != '0);
    assign push_ok_s = push_r && ((count_r < FULL_CNT) || pop_s);

    // Storage array; contents need no reset because pointers define validity.
    always_ff @(posedge sys_clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= word_r;
        end
    end

    // Pointers, occupancy, handshake and registered read outputs.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            overflow_r   <= 1'b0;
            ack_r        <= 1'b0;
            read_data_r  <= 32'h0000_0000;
            read_valid_r <= 1'b0;
        end else begin
            overflow_r   <= push_r && !push_ok_s;
            ack_r        <= read_req && (count_r != '0);
            read_valid_r <= pop_s;
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r    <= rd_ptr_r + ADDR_W'(1);
                read_data_r <= mem_r[rd_ptr_r];
            end else begin
                rd_ptr_r    <= rd_ptr_r;
                read_data_r <= read_data_r;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign read_req_ack    = ack_r;
    assign read_data       = read_data_r;
    assign read_data_valid = read_valid_r;
    assign word_count      = count_r;
    assign frame_err       = frame_err_r;
    assign overflow        = overflow_r;
    assign partial_drop    = partial_drop_r;

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Self-checking bench for uart_rx_word_packer. A queue-based reference model
// tracks expected FIFO contents and expected pulse counts from the byte
// stream that the bench puts on the line.
module tb_uart_rx_word_packer;

    localparam int CLK_FRE           = 16;
    localparam int BAUD_RATE         = 1000000;
    localparam int FIFO_DEPTH        = 16;
    localparam int IDLE_TIMEOUT_BITS = 20;
    localparam int C                 = CLK_FRE * 1000000 / BAUD_RATE;
    localparam int CW                = $clog2(FIFO_DEPTH) + 1;

    logic          sys_clk = 1'b0;
    logic          rst_n;
    logic          uart_rx;
    logic          read_req;
    logic          read_req_ack;
    logic          read_en;
    logic [31:0]   read_data;
    logic          read_data_valid;
    logic [CW-1:0] word_count;
    logic          frame_err;
    logic          overflow;
    logic          partial_drop;

    uart_rx_word_packer #(
        .CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD_RATE),
        .FIFO_DEPTH(FIFO_DEPTH), .IDLE_TIMEOUT_BITS(IDLE_TIMEOUT_BITS)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .uart_rx(uart_rx),
        .read_req(read_req), .read_req_ack(read_req_ack),
        .read_en(read_en), .read_data(read_data),
        .read_data_valid(read_data_valid), .word_count(word_count),
        .frame_err(frame_err), .overflow(overflow), .partial_drop(partial_drop)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed pulse counts (sampled on the falling clock edge)
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pd_cnt = 0;

    // Reference model state
    logic [31:0] model_q [$];
    logic [31:0] acc;
    int          nbytes = 0;
    int          exp_fe = 0;
    int          exp_ov = 0;
    int          exp_pd = 0;
    logic [31:0] last_data = 32'h0;

    always @(negedge sys_clk) begin
        if (rst_n === 1'b1) begin
            if (frame_err === 1'b1)    fe_cnt <= fe_cnt + 1;
            if (overflow === 1'b1)     ov_cnt <= ov_cnt + 1;
            if (partial_drop === 1'b1) pd_cnt <= pd_cnt + 1;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1, "time limit");
    end

    // ---------------- reference model ----------------
    task automatic model_byte(input logic [7:0] d, input bit ok);
        if (ok) begin
            if (nbytes == 0) acc = 32'h0;
            acc = acc + ({24'h0, d} << (8 * nbytes));
            nbytes++;
            if (nbytes == 4) begin
                if (model_q.size() < FIFO_DEPTH) model_q.push_back(acc);
                else exp_ov++;
                nbytes = 0;
            end
        end else begin
            exp_fe++;
            nbytes = 0;
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        nbytes    = 0;
        last_data = 32'h0;
    endtask

    // ---------------- line drivers ----------------
    task automatic drive_bit(input logic b);
        uart_rx = b;
        repeat (C) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(ok ? 1'b1 : 1'b0);
        model_byte(d, ok);
    endtask

    task automatic idle_line(input int bits);
        for (int i = 0; i < bits; i++) drive_bit(1'b1);
        if (bits >= IDLE_TIMEOUT_BITS && nbytes != 0) begin
            nbytes = 0;
            exp_pd++;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 1'b1);
    endtask

    // Pops one word (or tries to, if the model says the FIFO is empty) and checks it.
    task automatic pop_word();
        logic [31:0] exp;
        logic        has;
        has = (model_q.size() != 0);
        if (has) begin
            exp       = model_q.pop_front();
            last_data = exp;
        end else begin
            exp = last_data;
        end
        read_en = 1'b1;
        @(posedge sys_clk); #1;
        read_en = 1'b0;
        n_checks++;
        if (read_data_valid !== has) begin
            n_fail++;
            $display("FAIL pop_valid: got %b expected %b", read_data_valid, has);
        end
        n_checks++;
        if (read_data !== exp) begin
            n_fail++;
            $display("FAIL pop_data: got %h expected %h", read_data, exp);
        end
        n_checks++;
        if (word_count !== CW'(model_q.size())) begin
            n_fail++;
            $display("FAIL pop_count: got %0d expected %0d", word_count, model_q.size());
        end
        @(posedge sys_clk); #1;
        n_checks++;
        if (read_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pop_valid_pulse: got %b expected 0", read_data_valid);
        end
    endtask

    task automatic check_counts(input string tag);
        n_checks++;
        if (word_count !== CW'(model_q.size())) begin
            n_fail++;
            $display("FAIL %s word_count: got %0d expected %0d", tag, word_count, model_q.size());
        end
        n_checks++;
        if (fe_cnt !== exp_fe) begin
            n_fail++;
            $display("FAIL %s frame_err pulses: got %0d expected %0d", tag, fe_cnt, exp_fe);
        end
        n_checks++;
        if (ov_cnt !== exp_ov) begin
            n_fail++;
            $display("FAIL %s overflow pulses: got %0d expected %0d", tag, ov_cnt, exp_ov);
        end
        n_checks++;
        if (pd_cnt !== exp_pd) begin
            n_fail++;
            $display("FAIL %s partial_drop pulses: got %0d expected %0d", tag, pd_cnt, exp_pd);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        n_checks++;
        if ({read_req_ack, read_data_valid, frame_err, overflow, partial_drop} !== 5'b0) begin
            n_fail++;
            $display("FAIL %s flags: got %b expected 00000", tag,
                     {read_req_ack, read_data_valid, frame_err, overflow, partial_drop});
        end
        n_checks++;
        if (read_data !== 32'h0) begin
            n_fail++;
            $display("FAIL %s read_data: got %h expected 00000000", tag, read_data);
        end
        n_checks++;
        if (word_count !== CW'(0)) begin
            n_fail++;
            $display("FAIL %s word_count: got %0d expected 0", tag, word_count);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; uart_rx = 1'b1; read_req = 1'b0; read_en = 1'b0;
        repeat (3) @(posedge sys_clk); #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (3) @(posedge sys_clk); #1;
    endtask

    task automatic test_basic_word();
        send_word(32'h44332211);
        check_counts("basic");
        read_req = 1'b1;
        @(posedge sys_clk); #1;
        n_checks++;
        if (read_req_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL basic ack: got %b expected 1", read_req_ack);
        end
        pop_word();
        read_req = 1'b0;
        @(posedge sys_clk); #1;
        n_checks++;
        if (read_req_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL basic ack_drop: got %b expected 0", read_req_ack);
        end
    endtask

    task automatic test_frame_error();
        send_byte(8'h77, 1'b1);
        send_byte(8'hA5, 1'b0);
        idle_line(2);
        send_word(32'h04030201);
        check_counts("frame_err");
        pop_word();
    endtask

    task automatic test_glitch();
        uart_rx = 1'b0;
        repeat (4) @(posedge sys_clk); #1;
        idle_line(3);
        check_counts("glitch");
        send_word($urandom);
        check_counts("glitch_after");
        pop_word();
    endtask

    task automatic test_timeout();
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        idle_line(22);
        check_counts("timeout");
        send_word(32'h04030201);
        pop_word();
        // A gap well below the timeout keeps the partial word.
        send_byte(8'hAA, 1'b1);
        idle_line(10);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b1);
        check_counts("short_gap");
        pop_word();
    endtask

    task automatic test_overflow();
        logic [31:0] w;
        logic [31:0] exp;
        for (int i = 0; i < FIFO_DEPTH + 1; i++) send_word($urandom);
        check_counts("overflow");
        // Fill word whose push lands in the same cycle as a pop while full.
        w = $urandom;
        for (int b = 0; b < 3; b++) send_byte(w[8*b +: 8], 1'b1);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(w[24 + i]);
        uart_rx = 1'b1;
        // Push lands 12 clocks into the stop bit (sync + edge detect + half bit + register).
        repeat (11) @(posedge sys_clk); #1;
        exp = model_q.pop_front();
        last_data = exp;
        read_en = 1'b1;
        @(posedge sys_clk); #1;
        read_en = 1'b0;
        n_checks++;
        if (read_data_valid !== 1'b1 || read_data !== exp) begin
            n_fail++;
            $display("FAIL coincident_pop: got %b/%h expected 1/%h", read_data_valid, read_data, exp);
        end
        repeat (C - 12) @(posedge sys_clk); #1;
        model_byte(w[31:24], 1'b1);
        repeat (2) @(posedge sys_clk); #1;
        check_counts("coincident");
        for (int i = 0; i < FIFO_DEPTH; i++) pop_word();
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        bit         ok;
        for (int i = 0; i < 24; i++) begin
            d  = 8'($urandom);
            ok = ($urandom_range(0, 5) != 0);
            send_byte(d, ok);
            if (!ok) idle_line(2);
        end
        check_counts("b2b");
        while (model_q.size() != 0) pop_word();
    endtask

    task automatic test_empty_and_reset();
        pop_word();
        send_byte(8'h55, 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        uart_rx = 1'b1;
        model_reset();
        repeat (3) @(posedge sys_clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge sys_clk); #1;
        send_word(32'h40302010);
        check_counts("post_reset");
        pop_word();
    endtask

    initial begin
        test_reset();
        test_basic_word();
        test_frame_error();
        test_glitch();
        test_timeout();
        test_overflow();
        test_back_to_back();
        test_empty_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
